// File: rtl/drv_segment_scan.sv
// Multiplexed 7-segment scan driver: cycles digits through SHOW/GAP slots and
// double-buffers the display word so a frame never mixes old and new data.
module drv_segment_scan #(
    parameter int DIGITS   = 4,
    parameter int SHOW_CYC = 1000,
    parameter int GAP_CYC  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_blank,
    output logic [6:0]            o_drv_sgmnt,
    output logic [DIGITS-1:0]     o_drv_anode,
    output logic                  o_frame
);

    localparam int MAX_CYC = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC);
    localparam int IW      = $clog2(DIGITS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [1:0]              r_state;
    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*DIGITS-1:0]     r_act_val;
    logic [DIGITS-1:0]       r_act_blank;
    logic [4*DIGITS-1:0]     r_pend_val;
    logic [DIGITS-1:0]       r_pend_blank;
    logic                    r_ready;
    logic                    r_frame;
    logic [6:0]              r_sgmnt;
    logic [DIGITS-1:0]       r_anode;

    logic [1:0]              w_state_next;
    logic [CW-1:0]           w_cnt_next;
    logic [IW-1:0]           w_idx_next;
    logic                    w_frame_start;
    logic                    w_xfer;
    logic                    w_fire;
    logic [4*DIGITS-1:0]     w_act_val_next;
    logic [DIGITS-1:0]       w_act_blank_next;
    logic [3:0]              w_nib [DIGITS];
    logic [3:0]              w_cur_nib;
    logic                    w_cur_blank;
    logic [6:0]              w_sgmnt_next;
    logic [DIGITS-1:0]       w_anode_next;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_idx_next    = r_idx;
        w_frame_start = 1'b0;
        if (!i_enable) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next  = S_SHOW;
                    w_cnt_next    = '0;
                    w_idx_next    = '0;
                    w_frame_start = 1'b1;
                end
                S_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_next = S_GAP;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_next = S_SHOW;
                        w_cnt_next   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_next    = '0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_idx_next = r_idx + IW'(1);
                        end
                    end else begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
            endcase
        end
    end

    // A pending word exists exactly when o_ready is low; it only moves at frame start.
    assign w_xfer           = w_frame_start & ~r_ready;
    assign w_fire           = i_valid & r_ready;
    assign w_act_val_next   = w_xfer ? r_pend_val   : r_act_val;
    assign w_act_blank_next = w_xfer ? r_pend_blank : r_act_blank;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = w_act_val_next[gi*4 +: 4];
        end
    endgenerate

    // Outputs are built from next-state values so anode and segments switch together.
    assign w_cur_nib   = w_nib[w_idx_next];
    assign w_cur_blank = w_act_blank_next[w_idx_next];

    always_comb begin
        w_sgmnt_next = 7'b1111111;
        w_anode_next = '1;
        if (w_state_next == S_SHOW && !w_cur_blank) begin
            w_sgmnt_next = f_decode(w_cur_nib);
            w_anode_next = ~(DIGITS'(1) << w_idx_next);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_act_val    <= '0;
            r_act_blank  <= '1;
            r_pend_val   <= '0;
            r_pend_blank <= '0;
            r_ready      <= 1'b1;
            r_frame      <= 1'b0;
            r_sgmnt      <= 7'b1111111;
            r_anode      <= '1;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_act_val   <= w_act_val_next;
            r_act_blank <= w_act_blank_next;
            r_frame     <= w_frame_start;
            r_sgmnt     <= w_sgmnt_next;
            r_anode     <= w_anode_next;
            if (w_xfer) begin
                r_ready <= 1'b1;
            end else if (w_fire) begin
                r_pend_val   <= i_value;
                r_pend_blank <= i_blank;
                r_ready      <= 1'b0;
            end
        end
    end

    assign o_ready     = r_ready;
    assign o_frame     = r_frame;
    assign o_drv_sgmnt = r_sgmnt;
    assign o_drv_anode = r_anode;

endmodule

// File: tb/tb_drv_segment_scan.sv
// Directed bench for drv_segment_scan with DIGITS=4, SHOW_CYC=4, GAP_CYC=2
// (24-cycle frame); every output is checked each cycle inside whole frames.
module tb_drv_segment_scan;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        valid;
    logic        ready;
    logic [15:0] value;
    logic [3:0]  blank;
    logic [6:0]  sgmnt;
    logic [3:0]  anode;
    logic        frame;

    int checks = 0;
    int fails  = 0;
    logic [6:0] seg_tab [16];

    drv_segment_scan #(.DIGITS(4), .SHOW_CYC(4), .GAP_CYC(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_value     (value),
        .i_blank     (blank),
        .o_drv_sgmnt (sgmnt),
        .o_drv_anode (anode),
        .o_frame     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks one full frame starting at its first SHOW cycle (t=0), optionally
    // offering a word at cycle load_t and then holding junk on i_valid.
    task automatic run_frame(input string name, input logic [15:0] ev, input logic [3:0] eb,
                             input int load_t, input logic [15:0] lv, input logic [3:0] lb,
                             input bit hold);
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_sg;
        int d;
        int ph;
        one = 4'b0001;
        for (int t = 0; t < 24; t++) begin
            d  = t / 6;
            ph = t % 6;
            if (ph < 4 && !eb[d]) begin
                exp_an = ~(one << d);
                exp_sg = seg_tab[ev[d*4 +: 4]];
            end else begin
                exp_an = 4'hF;
                exp_sg = 7'h7F;
            end
            chk($sformatf("%s t%0d anode", name, t), 16'(anode), 16'(exp_an));
            chk($sformatf("%s t%0d sgmnt", name, t), 16'(sgmnt), 16'(exp_sg));
            chk($sformatf("%s t%0d frame", name, t), 16'(frame), 16'(t == 0));
            chk($sformatf("%s t%0d ready", name, t), 16'(ready),
                16'(load_t < 0 || t <= load_t));
            if (t == load_t) begin
                valid = 1'b1; value = lv; blank = lb;
            end else if (hold && load_t >= 0 && t > load_t) begin
                valid = 1'b1; value = 16'($urandom); blank = 4'($urandom);
            end else begin
                valid = 1'b0;
            end
            step();
        end
        valid = 1'b0;
        $display("frame %s checked: value=%h blank=%b", name, ev, eb);
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        rst_n = 1'b0; enable = 1'b0; valid = 1'b0; value = '0; blank = '0;
        step(); step();
        chk("rst ready", 16'(ready), 16'd1);
        chk("rst frame", 16'(frame), 16'd0);
        chk("rst sgmnt", 16'(sgmnt), 16'h7F);
        chk("rst anode", 16'(anode), 16'hF);
        rst_n = 1'b1;
        step();
        chk("idle anode", 16'(anode), 16'hF);
        $display("reset checked");

        // Load while disabled: word must wait in pending.
        valid = 1'b1; value = 16'h1A3F; blank = 4'b0000;
        step();
        valid = 1'b0;
        chk("cap ready", 16'(ready), 16'd0);
        step(); step(); step();
        chk("wait ready", 16'(ready), 16'd0);
        chk("wait anode", 16'(anode), 16'hF);
        chk("wait frame", 16'(frame), 16'd0);
        $display("pending wait checked");

        enable = 1'b1;
        step();
        run_frame("1A3F", 16'h1A3F, 4'b0000, 0, 16'h1111, 4'b0000, 1'b0);
        run_frame("1111", 16'h1111, 4'b0000, 12, 16'h2222, 4'b0000, 1'b0);
        run_frame("2222", 16'h2222, 4'b0000, 3, 16'h8888, 4'b0100, 1'b1);
        run_frame("8888b", 16'h8888, 4'b0100, -1, 16'h0, 4'b0, 1'b0);

        // Drop enable while digit1 is lit.
        for (int i = 0; i < 7; i++) step();
        chk("dig1 anode", 16'(anode), 16'hD);
        chk("dig1 sgmnt", 16'(sgmnt), 16'h00);
        enable = 1'b0;
        step();
        chk("dis anode", 16'(anode), 16'hF);
        chk("dis sgmnt", 16'(sgmnt), 16'h7F);
        chk("dis frame", 16'(frame), 16'd0);
        step(); step();
        chk("dis2 anode", 16'(anode), 16'hF);
        enable = 1'b1;
        step();
        $display("disable/re-enable checked");
        run_frame("reen", 16'h8888, 4'b0100, -1, 16'h0, 4'b0, 1'b0);

        // Async reset in GAP with a word pending.
        valid = 1'b1; value = 16'h5555; blank = 4'b0000;
        step();
        valid = 1'b0;
        chk("pre-rst ready", 16'(ready), 16'd0);
        step(); step(); step();
        chk("gap anode", 16'(anode), 16'hF);
        rst_n = 1'b0;
        #1;
        chk("arst ready", 16'(ready), 16'd1);
        chk("arst anode", 16'(anode), 16'hF);
        chk("arst sgmnt", 16'(sgmnt), 16'h7F);
        chk("arst frame", 16'(frame), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        $display("async reset checked");
        run_frame("blank", 16'h0000, 4'b1111, 5, 16'hC0DE, 4'b0000, 1'b0);
        run_frame("C0DE", 16'hC0DE, 4'b0000, -1, 16'h0, 4'b0, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/drv_segment_scan.md
DRV_SEGMENT_SCAN -- requirements
Module: drv_segment_scan

Interface
REQ-001 Parameter: DIGITS, default 4, number of multiplexed 7-segment digits (legal 2..8).
REQ-002 Parameter: SHOW_CYC, default 1000, clock cycles a digit is lit (legal >= 2).
REQ-003 Parameter: GAP_CYC, default 16, clock cycles all anodes are off between digits (legal >= 1).
REQ-004 Port: i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: i_rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-006 Port: i_enable  input  1  scan enable; low blanks the display.
REQ-007 Port: i_valid  input  1  new display word offered.
REQ-008 Port: o_ready  output  1  block can accept a new display word.
REQ-009 Port: i_value  input  4*DIGITS  hex nibbles; nibble k drives digit k (digit 0 = bits 3:0).
REQ-010 Port: i_blank  input  DIGITS  per-digit blank mask, sampled with i_value.
REQ-011 Port: o_drv_sgmnt  output  7  segment lines, active-low; bit0=a(top), 1=b, 2=c, 3=d, 4=e, 5=f, 6=g(middle).
REQ-012 Port: o_drv_anode  output  DIGITS  digit select, active-low, at most one bit low.
REQ-013 Port: o_frame  output  1  one-cycle pulse at start of each frame.

Function
REQ-014 FSM states: IDLE, SHOW, GAP.
- IDLE: all anodes high.
- SHOW: current digit lit.
- GAP: all anodes high.
REQ-015 Transitions:
- IDLE->SHOW when i_enable=1, with digit index 0 and cycle counter 0.
- SHOW->GAP after exactly SHOW_CYC cycles in SHOW.
- GAP->SHOW after exactly GAP_CYC cycles in GAP; digit index increments, wrapping DIGITS-1 -> 0.
REQ-016 i_enable=0 in any state forces IDLE on the next edge; counter and digit index clear to 0.
REQ-017 Display double-buffer:
- Handshake fires when i_valid=1 and o_ready=1 on the same edge.
- The firing edge captures i_value/i_blank into a pending register.
- o_ready deasserts on the cycle after capture.
- Pending transfers to the active register at the next frame start.
- o_ready reasserts the cycle after that transfer.
REQ-018 Frame start is the SHOW entry with digit index 0, from IDLE or from GAP after the wrap. o_frame is high in the first SHOW cycle of that entry only.
REQ-019 Pending-to-active transfer occurs on the edge entering frame-start SHOW, so digit 0 of that frame already shows new data. No partial frame ever mixes old and new words.
REQ-020 i_valid with o_ready=0 is ignored; the data is not captured and nothing is queued.
REQ-021 In SHOW:
- o_drv_anode has only bit [index] low.
- o_drv_sgmnt = decode(active nibble[index]).
- If active blank[index]=1, o_drv_anode is all high and o_drv_sgmnt = 7'b1111111, with timing unchanged.
REQ-022 Outside SHOW, o_drv_sgmnt = 7'b1111111 and o_drv_anode is all ones.
REQ-023 Decode (g..a, active-low):
- 0=1000000, 1=1111001, 2=0100100, 3=0110000
- 4=0011001, 5=0010010, 6=0000010, 7=1111000
- 8=0000000, 9=0010000, A=0001000, b=0000011
- C=1000110, d=0100001, E=0000110, F=0001110
REQ-024 All outputs are registered. Anode and segment changes occur on the same edge as the state change (no glitch between anode and segment update).
REQ-025 Frame period is DIGITS*(SHOW_CYC+GAP_CYC) cycles while enabled.
REQ-026 Width rules:
- Cycle counter is $clog2(max(SHOW_CYC,GAP_CYC)) bits minimum, with no overflow.
- Digit index is $clog2(DIGITS) bits and is compared against DIGITS-1 (non-power-of-2 DIGITS legal).
REQ-027 Pending data waits while i_enable=0. Transfer happens at the first frame start after re-enable.

Reset
REQ-028 While i_rst_n=0:
- state=IDLE, counter=0, index=0.
- active value=0, active blank all ones, pending cleared.
- o_ready=1, o_frame=0, o_drv_sgmnt=7'b1111111, o_drv_anode all ones.
REQ-029 Reset asserted mid-SHOW immediately (asynchronously) blanks all outputs. After release, the first enabled frame shows all digits blank until a word is loaded.

Verification
REQ-030 DIGITS=4, SHOW_CYC=4, GAP_CYC=2, enable high, load 16'h1A3F blank=0 -> next frame lights:
- digit0: sgmnt 0001110 (F), anode 1110
- digit1: 0110000 (3), anode 1101
- digit2: 0001000 (A), anode 1011
- digit3: 1111001 (1), anode 0111
- each digit lit exactly 4 cycles, with 2 dark cycles between; o_frame every 24 cycles.
REQ-031 Load 16'h1111 then, mid-frame at digit2, load 16'h2222 -> digits 2..3 of the current frame still show 1; the next frame shows 2 on all digits; o_ready is low from the cycle after capture until the cycle after the frame-start transfer.
REQ-032 Hold i_valid=1 with o_ready=0 and varying data -> only the word present on the accepting edge is ever displayed.
REQ-033 blank=4'b0100 with value 16'h8888 -> digit2 slot shows anodes 1111 and sgmnt 1111111; other digits show 0000000.
REQ-034 Drop i_enable mid-SHOW of digit1 -> IDLE, all dark next cycle. Re-enable -> restarts at digit0 with an o_frame pulse.
REQ-035 Assert i_rst_n=0 asynchronously mid-GAP, then release -> outputs blank immediately, o_ready=1, and the display stays blank until a new word loads.
